// File: rtl/fir_lane_packer.sv
// Packs per-channel sample beats into PSAMPLES-deep lane words for a decimating FIR.
// A flush request closes a partial word early; unused lanes are zero and m_tlast flags it.
module fir_lane_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int PSAMPLES   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_tvalid,
  output logic                                    s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]          s_tdata,
  input  logic                                    flush,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0] m_tdata,
  output logic                                    m_tlast
);

  localparam int WORD_W = CHANNELS * DATA_WIDTH * PSAMPLES;
  localparam int CNT_W  = (PSAMPLES > 1) ? $clog2(PSAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PSAMPLES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              pend_q, pend_d;
  logic              out_free_s;
  logic              ready_s;
  logic              accept_s;

  // Keeps lanes below n in every channel; lanes n and above are forced to zero.
  function automatic logic [WORD_W-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < PSAMPLES; k++) begin
        if (k < int'(n)) begin
          m[(c*PSAMPLES + k)*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b1}};
        end else begin
          m[(c*PSAMPLES + k)*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        end
      end
    end
    return m;
  endfunction

  // Handshake qualifiers; the wrapping beat may ride on a same-cycle drain.
  always_comb begin
    out_free_s = !valid_q || m_tready;
    ready_s    = !pend_q && ((cnt_q != LAST_LANE) || out_free_s);
    accept_s   = s_tvalid && ready_s;
  end

  // Next-state: lane fill, word handoff, and flush bookkeeping.
  always_comb begin
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;
    last_d  = last_q;
    pend_d  = pend_q;
    if (valid_q && m_tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (accept_s) begin
      for (int c = 0; c < CHANNELS; c++) begin
        fill_d[(c*PSAMPLES + int'(cnt_q))*DATA_WIDTH +: DATA_WIDTH] =
          s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
      if (cnt_q == LAST_LANE) begin
        // A flush arriving with the completing beat has nothing left to pad.
        data_d  = fill_d;
        valid_d = 1'b1;
        last_d  = 1'b0;
        cnt_d   = '0;
        fill_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        pend_d = flush;
      end
    end else if (pend_q && out_free_s) begin
      data_d  = fill_q & keep_mask(cnt_q);
      valid_d = 1'b1;
      last_d  = 1'b1;
      cnt_d   = '0;
      fill_d  = '0;
      pend_d  = 1'b0;
    end else if (flush && (cnt_q != '0)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign s_tready = ready_s;
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;

endmodule

// File: tb/tb_fir_lane_packer.sv
// Directed and randomized bench for fir_lane_packer; a beat-list model predicts each
// packed word, which is compared bit-exact whenever the DUT hands a word downstream.
module tb_fir_lane_packer;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int PS = 8;
  localparam int IW = CH * DW;
  localparam int OW = IW * PS;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid;
  logic          s_tready;
  logic [IW-1:0] s_tdata;
  logic          flush;
  logic          m_tvalid;
  logic          m_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tlast;

  int checks  = 0;
  int errors  = 0;
  int n_words = 0;

  logic [IW-1:0] cur[$];
  logic [OW-1:0] exp_data[$];
  logic          exp_last[$];
  logic          s_fire;
  logic          m_fire;

  always #5 clk = ~clk;

  fir_lane_packer #(.DATA_WIDTH(DW), .CHANNELS(CH), .PSAMPLES(PS)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .flush    (flush),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast)
  );

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Model: beat k of the collected list goes to lane k of each channel, rest zero.
  task automatic emit(input logic last);
    logic [OW-1:0] w;
    logic [IW-1:0] b;
    w = '0;
    for (int k = 0; k < cur.size(); k++) begin
      b = cur[k];
      for (int c = 0; c < CH; c++) w[(c*PS + k)*DW +: DW] = b[c*DW +: DW];
    end
    exp_data.push_back(w);
    exp_last.push_back(last);
    cur.delete();
  endtask

  task automatic step(input logic vld, input logic [IW-1:0] dat, input logic fl, input logic rdy);
    @(negedge clk);
    s_tvalid = vld;
    s_tdata  = dat;
    flush    = fl;
    m_tready = rdy;
    #1;
    s_fire = vld && s_tready && !rst;
    m_fire = m_tvalid && rdy && !rst;
    if (rst) begin
      cur.delete();
      exp_data.delete();
      exp_last.delete();
    end else begin
      if (m_fire) begin
        n_words++;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_word: observed word %h, expected no word", m_tdata);
        end else begin
          check("word_data", m_tdata, exp_data.pop_front());
          check("word_last", OW'(m_tlast), OW'(exp_last.pop_front()));
        end
      end
      if (s_fire) cur.push_back(dat);
      if (cur.size() == PS) emit(1'b0);
      else if (fl && cur.size() > 0) emit(1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] exp_w;
    logic [OW-1:0] held;
    logic [IW-1:0] b16;
    int            w0;
    int            acc;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; flush = 1'b0; m_tready = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hdead_beef, 1'b1, 1'b1);
    check("rst_valid", OW'(m_tvalid), OW'(0));
    check("rst_last", OW'(m_tlast), OW'(0));
    check("rst_data", m_tdata, '0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_ready", OW'(s_tready), OW'(1));

    // Full word with known lane contents.
    for (int k = 0; k < PS; k++) step(1'b1, {16'(16'h101 + k), 16'(k + 1)}, 1'b0, 1'b1);
    exp_w = '0;
    for (int k = 0; k < PS; k++) begin
      exp_w[k*DW +: DW]        = 16'(k + 1);
      exp_w[(PS + k)*DW +: DW] = 16'(16'h101 + k);
    end
    check("full_valid", OW'(m_tvalid), OW'(1));
    check("full_data", m_tdata, exp_w);
    check("full_last", OW'(m_tlast), OW'(0));
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: second word completes only while the first drains.
    held = '0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      check("bp_accept", OW'(s_fire), OW'(1));
      if (i == 7) held = m_tdata;
    end
    b16 = $urandom;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b16, 1'b0, 1'b0);
      check("bp_stall", OW'(s_fire), OW'(0));
      check("bp_valid", OW'(m_tvalid), OW'(1));
      check("bp_hold", m_tdata, held);
    end
    step(1'b1, b16, 1'b0, 1'b1);
    check("bp_release", OW'(s_fire), OW'(1));
    step(1'b0, '0, 1'b0, 1'b1);
    check("bp_drained", OW'(m_tvalid), OW'(0));

    // Partial word closed by flush.
    for (int i = 0; i < 3; i++) step(1'b1, {16'($urandom), 16'h7fff}, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_valid", OW'(m_tvalid), OW'(1));
    check("flush_last", OW'(m_tlast), OW'(1));
    check("flush_keep", OW'(m_tdata[0 +: 3*DW]), OW'({3{16'h7fff}}));
    check("flush_pad", OW'(m_tdata[3*DW +: 5*DW]), OW'(0));
    for (int i = 0; i < PS; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    check("after_flush_last", OW'(m_tlast), OW'(0));
    step(1'b0, '0, 1'b0, 1'b1);

    // Flush on an empty buffer, then flush together with the completing beat.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("empty_flush", OW'(m_tvalid), OW'(0));
    for (int i = 0; i < PS - 1; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    check("wrap_flush_valid", OW'(m_tvalid), OW'(1));
    check("wrap_flush_last", OW'(m_tlast), OW'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    check("wrap_flush_none1", OW'(m_tvalid), OW'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    check("wrap_flush_none2", OW'(m_tvalid), OW'(0));

    // Reset in the middle of a word discards it.
    w0 = n_words;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < PS; i++) step(1'b1, {16'(16'h10 + i), 16'(16'h10 + i)}, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("rst_mid_words", OW'(n_words - w0), OW'(1));

    // Random streaming with random downstream stalls.
    w0  = n_words;
    acc = 0;
    for (int cyc = 0; cyc < 6000 && acc < 800; cyc++) begin
      step($urandom_range(0, 3) != 0, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      if (s_fire) acc++;
    end
    check("stream_beats", OW'(acc), OW'(800));
    for (int cyc = 0; cyc < 50 && exp_data.size() > 0; cyc++) step(1'b0, '0, 1'b0, 1'b1);
    check("stream_words", OW'(n_words - w0), OW'(100));
    check("stream_pending", OW'(exp_data.size()), OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
